avl_memtest: RTL
================

AVL_MEMTEST -- requirements
Module: avl_memtest

Interface
REQ-001 SHALL have parameter SEED, default 32'hACE1_0001; LFSR seed, and SHALL treat a value of 0 as 32'h0000_0001.
REQ-002 SHALL have parameter MAX_OUTST, default 4; maximum outstanding read requests, legal range 1..15.
REQ-003 SHALL use one clock and a synchronous, active-low reset: i_clk  in  1  clock; i_rst_n  in  1  reset, sampled on the i_clk rising edge.
REQ-004 SHALL have these control ports:
- i_start  in  1  pulse; starts a run.
- i_base  in  26  first word address.
- i_len  in  16  number of 64-bit words.
- o_busy  out  1  run in progress.
- o_done  out  1  run finished; held until the next start.
- o_pass  out  1  result; valid while o_done.
- o_err_cnt  out  16  mismatch count.
REQ-005 SHALL have these Avalon initiator ports:
- avl_ready  in  1
- avl_burstbegin  out  1
- avl_adr  out  26
- avl_dat  out  64
- avl_be  out  8
- avl_wr_req  out  1
- avl_rdt_req  out  1
- avl_size  out  3
- avl_rdt  in  64
- avl_rdt_valid  in  1
REQ-006 SHALL have these calibration inputs: local_init_done  in  1; local_cal_success  in  1.
REQ-007 SHALL have these error-log ports: o_first_err_adr  out  26; o_first_err_dat  out  64; both subject to REQ-027.

Function
REQ-008 SHALL implement an FSM with states IDLE, WAIT_CAL, WRITE, READ, DRAIN, DONE.
REQ-009 IDLE→WAIT_CAL SHALL occur on i_start; i_base and i_len SHALL be latched, o_busy=1, o_done=0, o_err_cnt=0, and the write LFSR SHALL load SEED.
REQ-010 WAIT_CAL SHALL behave as follows:
- local_init_done=1 and local_cal_success=1 → WRITE; if the latched length is 0 → DONE with o_pass=1.
- local_init_done=1 and local_cal_success=0 → DONE with o_pass=0 and o_err_cnt=0.
REQ-011 Pattern SHALL be a 32-bit Galois LFSR, mask 32'h8020_0003, shifted right; the word SHALL be {lfsr, ~lfsr}; the LFSR SHALL advance once per accepted beat.
REQ-012 Every request SHALL be single-beat: avl_size=1, avl_be=8'hFF, avl_burstbegin=1 with each request; avl_wr_req and avl_rdt_req SHALL never be high together.
REQ-013 A request SHALL be accepted on a cycle where req=1 and avl_ready=1; address and data SHALL stay stable while avl_ready=0.
REQ-014 In WRITE, word k SHALL go to address (base+k) mod 2^26; wrap past 26'h3FFFFFF is legal.
REQ-015 WRITE→READ SHALL occur after len accepted writes; the read-issue index SHALL reset to 0 and the expected-data LFSR SHALL reload SEED.
REQ-016 READ SHALL issue reads back-to-back while outstanding<MAX_OUTST; outstanding SHALL count +1 per accept and −1 per avl_rdt_valid, with both in the same cycle giving net 0.
REQ-017 Reads SHALL be issued in address order; responses SHALL be compared in order against the expected LFSR word, and the expected LFSR SHALL advance per avl_rdt_valid.
REQ-018 READ→DRAIN SHALL occur after len reads are accepted; DRAIN→DONE SHALL occur when outstanding=0 and the final response is compared.
REQ-019 Each mismatch SHALL increment o_err_cnt, saturating at 16'hFFFF.
REQ-020 DONE SHALL set o_busy=0, o_done=1, o_pass=(o_err_cnt==0).
REQ-021 DONE SHALL move to WAIT_CAL on i_start, acting as in REQ-009.
REQ-022 i_start SHALL be ignored while o_busy=1.
REQ-023 avl_rdt_valid with outstanding=0 SHALL be ignored: not compared, no counter change.
REQ-024 Latency: the first write request SHALL assert one cycle after WAIT_CAL sees calibration good.

Reset
REQ-025 On i_rst_n=0 at a rising edge, the block SHALL enter IDLE and all outputs SHALL become 0, except avl_size=3'd1 and avl_be=8'hFF.
REQ-026 Reset mid-run SHALL drop avl_wr_req/avl_rdt_req on that edge; responses arriving afterwards SHALL be ignored.

Configuration
REQ-027 Macro AVL_MEMTEST_ERRLOG_EN SHALL control the error log:
- Defined: on the first mismatch of a run, o_first_err_adr and o_first_err_dat SHALL capture the address and the received data; both SHALL clear on start.
- Undefined: both outputs SHALL be constant 0 with no capture registers.

Verification
REQ-028 Ideal responder (avl_ready=1, read latency 3 cycles), base=0, len=16 → 16 writes then 16 reads, o_done=1, o_pass=1, o_err_cnt=0.
REQ-029 Responder corrupts bit 5 of the read of address 7, base=0, len=16 → o_err_cnt=1, o_pass=0; with ERRLOG: o_first_err_adr=7.
REQ-030 local_init_done=1, local_cal_success=0 → no requests issued, o_done=1, o_pass=0.
REQ-031 base=26'h3FFFFFE, len=4, avl_ready toggling every cycle → addresses 3FFFFFE, 3FFFFFF, 0, 1 in both phases; request signals stable while stalled; o_pass=1.
REQ-032 Latency 10 cycles, MAX_OUTST=4 → never more than 4 reads outstanding; len=0 → o_done with o_pass=1 and no requests.
REQ-033 i_rst_n=0 during READ at word 5 of 16 → the next cycle shows IDLE, all outputs reset, and a late avl_rdt_valid does not change o_err_cnt.

Source files
------------

// File: rtl/avl_memtest_if.sv
// Avalon-MM single-beat initiator bus used by avl_memtest.
// The master modport is the tester side; the slave modport is the memory/controller side.
interface avl_memtest_if;
    logic        avl_ready;
    logic        avl_burstbegin;
    logic [25:0] avl_adr;
    logic [63:0] avl_dat;
    logic [7:0]  avl_be;
    logic        avl_wr_req;
    logic        avl_rdt_req;
    logic [2:0]  avl_size;
    logic [63:0] avl_rdt;
    logic        avl_rdt_valid;

    modport master (
        input  avl_ready, avl_rdt, avl_rdt_valid,
        output avl_burstbegin, avl_adr, avl_dat, avl_be, avl_wr_req, avl_rdt_req, avl_size
    );

    modport slave (
        output avl_ready, avl_rdt, avl_rdt_valid,
        input  avl_burstbegin, avl_adr, avl_dat, avl_be, avl_wr_req, avl_rdt_req, avl_size
    );
endinterface

// File: rtl/avl_memtest.sv
// avl_memtest: LFSR write/read-back memory tester over an Avalon-MM initiator.
// Writes len words of {lfsr, ~lfsr} starting at base, reads them back with up to
// MAX_OUTST reads in flight, and counts mismatching responses.
// Optional macro AVL_MEMTEST_ERRLOG_EN: capture address/data of the first mismatch.
module avl_memtest #(
    parameter logic [31:0] SEED      = 32'hACE1_0001,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [25:0]   i_base,
    input  logic [15:0]   i_len,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_pass,
    output logic [15:0]   o_err_cnt,
    input  logic          local_init_done,
    input  logic          local_cal_success,
    output logic [25:0]   o_first_err_adr,
    output logic [63:0]   o_first_err_dat,
    avl_memtest_if.master avl
);

    localparam logic [31:0] SEED_EFF  = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    localparam logic [3:0]  OUTST_MAX = 4'(MAX_OUTST);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_CAL,
        WRITE,
        READ,
        DRAIN,
        DONE
    } state_t;

    // Galois LFSR, shifted right; taps applied when the bit shifted out is 1.
    function automatic logic [31:0] lfsr_next(input logic [31:0] l);
        return {1'b0, l[31:1]} ^ (l[0] ? LFSR_MASK : 32'd0);
    endfunction

    function automatic logic [63:0] pat_word(input logic [31:0] l);
        return {l, ~l};
    endfunction

    state_t      state;
    logic [25:0] base_q;
    logic [15:0] len_q;
    logic [15:0] wr_cnt;
    logic [15:0] rd_cnt;
    logic [31:0] wr_lfsr;
    logic [31:0] exp_lfsr;
    logic [3:0]  outst;
    logic        wr_req;
    logic        rd_req;
    logic [25:0] adr;
    logic [63:0] dat;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_cnt;

    logic        wr_acc;
    logic        rd_acc;
    logic        rsp_vld;
    logic        rsp_mis;
    logic        start_go;
    logic [3:0]  outst_nxt;
    logic [15:0] err_nxt;
    logic [15:0] rd_cnt_nxt;

    assign wr_acc     = wr_req & avl.avl_ready;
    assign rd_acc     = rd_req & avl.avl_ready;
    // A response only counts while reads are in flight; stray ones are dropped.
    assign rsp_vld    = avl.avl_rdt_valid && (outst != 4'd0) &&
                        ((state == READ) || (state == DRAIN));
    assign rsp_mis    = rsp_vld && (avl.avl_rdt != pat_word(exp_lfsr));
    assign start_go   = i_start && ((state == IDLE) || (state == DONE));
    assign outst_nxt  = outst + 4'(rd_acc) - 4'(rsp_vld);
    assign err_nxt    = (rsp_mis && (err_cnt != 16'hFFFF)) ? err_cnt + 16'd1 : err_cnt;
    assign rd_cnt_nxt = rd_cnt + 16'(rd_acc);

    assign avl.avl_wr_req     = wr_req;
    assign avl.avl_rdt_req    = rd_req;
    assign avl.avl_burstbegin = wr_req | rd_req;
    assign avl.avl_adr        = adr;
    assign avl.avl_dat        = dat;
    assign avl.avl_be         = 8'hFF;
    assign avl.avl_size       = 3'd1;

    assign o_busy    = busy;
    assign o_done    = done;
    assign o_pass    = pass;
    assign o_err_cnt = err_cnt;

    // Test sequencer: run control, request generation, in-flight tracking and checking.
    // NOTE: all state here is updated with non-blocking assignments so every branch
    // sees the pre-edge values; the combinational *_nxt/acc terms carry same-cycle effects.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            base_q   <= '0;
            len_q    <= '0;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            wr_lfsr  <= '0;
            exp_lfsr <= '0;
            outst    <= '0;
            wr_req   <= 1'b0;
            rd_req   <= 1'b0;
            adr      <= '0;
            dat      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
        end else begin
            outst   <= outst_nxt;
            err_cnt <= err_nxt;
            if (rsp_vld) begin
                exp_lfsr <= lfsr_next(exp_lfsr);
            end

            case (state)
                IDLE, DONE: begin
                    if (i_start) begin
                        state   <= WAIT_CAL;
                        base_q  <= i_base;
                        len_q   <= i_len;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        pass    <= 1'b0;
                        err_cnt <= '0;
                        wr_lfsr <= SEED_EFF;
                    end
                end

                WAIT_CAL: begin
                    if (local_init_done) begin
                        if (!local_cal_success) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= 1'b0;
                        end else if (len_q == 16'd0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            state  <= WRITE;
                            wr_req <= 1'b1;
                            adr    <= base_q;
                            dat    <= pat_word(wr_lfsr);
                            wr_cnt <= '0;
                        end
                    end
                end

                WRITE: begin
                    if (wr_acc) begin
                        wr_lfsr <= lfsr_next(wr_lfsr);
                        if (wr_cnt == len_q - 16'd1) begin
                            state    <= READ;
                            wr_req   <= 1'b0;
                            rd_cnt   <= '0;
                            exp_lfsr <= SEED_EFF;
                        end else begin
                            wr_cnt <= wr_cnt + 16'd1;
                            adr    <= adr + 26'd1;
                            dat    <= pat_word(lfsr_next(wr_lfsr));
                        end
                    end
                end

                READ: begin
                    rd_cnt <= rd_cnt_nxt;
                    if (rd_acc && (rd_cnt_nxt == len_q)) begin
                        state  <= DRAIN;
                        rd_req <= 1'b0;
                    end else if (!rd_req || avl.avl_ready) begin
                        // A stalled request holds; otherwise issue next if a slot is free.
                        rd_req <= (outst_nxt < OUTST_MAX);
                        adr    <= base_q + 26'(rd_cnt_nxt);
                    end
                end

                DRAIN: begin
                    if (outst_nxt == 4'd0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_nxt == 16'd0);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

`ifdef AVL_MEMTEST_ERRLOG_EN
    logic [15:0] rsp_idx;
    logic [25:0] first_err_adr;
    logic [63:0] first_err_dat;

    // First-mismatch log; the response index maps each read-back to its address.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rsp_idx       <= '0;
            first_err_adr <= '0;
            first_err_dat <= '0;
        end else if (start_go) begin
            rsp_idx       <= '0;
            first_err_adr <= '0;
            first_err_dat <= '0;
        end else begin
            if (rsp_vld) begin
                rsp_idx <= rsp_idx + 16'd1;
            end
            if (rsp_mis && (err_cnt == 16'd0)) begin
                first_err_adr <= base_q + 26'(rsp_idx);
                first_err_dat <= avl.avl_rdt;
            end
        end
    end

    assign o_first_err_adr = first_err_adr;
    assign o_first_err_dat = first_err_dat;
`else
    assign o_first_err_adr = '0;
    assign o_first_err_dat = '0;
`endif

endmodule
